// File: rtl/par_to_serial.sv
// Byte-to-bit serializer: sends IDLE_WORD sync frames after reset, then
// transmits accepted bytes MSB first, one 8-cycle frame per byte.
module par_to_serial #(
  parameter logic [7:0]  IDLE_WORD   = 8'hBC,
  parameter int unsigned SYNC_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       serial_out,
  output logic       frame_start,
  output logic       active,
  output logic       overrun,
  output logic [7:0] data_count
);

  localparam int unsigned CntW  = 3;
  localparam int unsigned SyncW = 4;
  localparam logic [CntW-1:0]  LastBit  = CntW'(7);
  localparam logic [CntW-1:0]  PreLast  = CntW'(6);
  localparam logic [SyncW-1:0] SyncLast = SyncW'(SYNC_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_RST    = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]       shift_q, shift_d;
  logic [SyncW-1:0] sync_cnt_q, sync_cnt_d;
  logic             serial_q, serial_d;
  logic             frame_start_q, frame_start_d;
  logic             ready_q, ready_d;
  logic             active_q, active_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       count_q, count_d;
  logic [7:0]       load_word;
  logic             boundary;
  logic             accept;

  assign boundary = (bit_cnt_q == LastBit);
  // ready_q is only ever high in ACTIVE on the last bit, so this is the accept edge
  assign accept   = valid_in & ready_q;

  // Next-state, frame sequencing and output computation
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q + CntW'(1);
    shift_d       = {shift_q[5:0], 1'b0};
    serial_d      = shift_q[6];
    frame_start_d = 1'b0;
    sync_cnt_d    = sync_cnt_q;
    overrun_d     = overrun_q | (valid_in & ~ready_q);
    count_d       = count_q;
    load_word     = IDLE_WORD;

    unique case (state_q)
      ST_RST: begin
        state_d    = ST_SYNC;
        sync_cnt_d = '0;
      end
      ST_SYNC: begin
        if (bit_cnt_q == PreLast) begin
          if (sync_cnt_q == SyncLast) begin
            state_d = ST_ACTIVE;
          end else begin
            sync_cnt_d = sync_cnt_q + SyncW'(1);
          end
        end
      end
      ST_ACTIVE: begin
        if (accept) begin
          load_word = data_in;
          count_d   = count_q + 8'd1;
        end
      end
      default: state_d = ST_RST;
    endcase

    if (boundary) begin
      bit_cnt_d     = '0;
      serial_d      = load_word[7];
      shift_d       = load_word[6:0];
      frame_start_d = 1'b1;
    end

    active_d = (state_d == ST_ACTIVE);
    ready_d  = (state_d == ST_ACTIVE) && (bit_cnt_d == LastBit);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RST;
      bit_cnt_q     <= LastBit;
      shift_q       <= '0;
      sync_cnt_q    <= '0;
      serial_q      <= 1'b0;
      frame_start_q <= 1'b0;
      ready_q       <= 1'b0;
      active_q      <= 1'b0;
      overrun_q     <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      sync_cnt_q    <= sync_cnt_d;
      serial_q      <= serial_d;
      frame_start_q <= frame_start_d;
      ready_q       <= ready_d;
      active_q      <= active_d;
      overrun_q     <= overrun_d;
      count_q       <= count_d;
    end
  end

  assign ready_out   = ready_q;
  assign serial_out  = serial_q;
  assign frame_start = frame_start_q;
  assign active      = active_q;
  assign overrun     = overrun_q;
  assign data_count  = count_q;

endmodule

// File: tb/tb_par_to_serial.sv
// Self-checking bench for par_to_serial against a frame-level reference model.
module tb_par_to_serial;

  localparam logic [7:0]  IDLE = 8'hBC;
  localparam int unsigned SYNC = 4;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       serial_out;
  logic       frame_start;
  logic       active;
  logic       overrun;
  logic [7:0] data_count;

  par_to_serial #(.IDLE_WORD(IDLE), .SYNC_FRAMES(SYNC)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .serial_out (serial_out),
    .frame_start(frame_start),
    .active     (active),
    .overrun    (overrun),
    .data_count (data_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Reference model: t counts edges since reset release (E0 -> t=0).
  // Frame f = t/8 carries word_m; bit position k = t%8 shows word_m[7-k].
  int         t       = -1;
  logic [7:0] word_m  = 8'h00;
  logic [7:0] count_m = 8'h00;
  logic       ovr_m   = 1'b0;
  logic       rdy_m   = 1'b0;
  logic       act_m   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model by one edge, compare all outputs.
  task automatic cycle(input logic r, input logic v, input logic [7:0] d);
    logic exp_ser;
    logic exp_fs;
    int   k;
    reset    = r;
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    #1;
    if (r) begin
      t = -1; ovr_m = 1'b0; count_m = 8'h00; rdy_m = 1'b0; act_m = 1'b0; word_m = 8'h00;
      exp_ser = 1'b0;
      exp_fs  = 1'b0;
    end else begin
      if (v && !rdy_m) ovr_m = 1'b1;
      t++;
      k = t % 8;
      if (k == 0) begin
        if (v && rdy_m) begin
          word_m  = d;
          count_m = count_m + 8'd1;
        end else begin
          word_m = IDLE;
        end
      end
      act_m   = (t >= 8 * SYNC - 1);
      rdy_m   = act_m && (k == 7);
      exp_ser = word_m[7 - k];
      exp_fs  = (k == 0);
    end
    check("serial_out",  32'(serial_out),  32'(exp_ser));
    check("frame_start", 32'(frame_start), 32'(exp_fs));
    check("ready_out",   32'(ready_out),   32'(rdy_m));
    check("active",      32'(active),      32'(act_m));
    check("overrun",     32'(overrun),     32'(ovr_m));
    check("data_count",  32'(data_count),  32'(count_m));
  endtask

  // Idle until the model says the next edge is an accepting edge (bounded).
  task automatic to_ready();
    for (int i = 0; i < 64 && !rdy_m; i++) cycle(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = 8'h00;

    // Reset, release, sync frames until ACTIVE
    repeat (3) cycle(1'b1, 1'b0, 8'h00);
    to_ready();
    check("first_ready_t", 32'(t), 32'(8 * SYNC - 1));

    // Single byte in the first ready cycle
    cycle(1'b0, 1'b1, 8'hA5);
    repeat (15) cycle(1'b0, 1'b0, 8'h00);
    check("count_after_a5", 32'(data_count), 32'd1);

    // Back-to-back bytes on consecutive ready cycles
    to_ready();
    cycle(1'b0, 1'b1, 8'h01);
    repeat (7) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'hFF);
    repeat (15) cycle(1'b0, 1'b0, 8'h00);
    check("count_after_pair", 32'(data_count), 32'd3);

    // Fill to 256 accepted bytes, wrapping the counter
    for (int n = 0; n < 253; n++) begin
      to_ready();
      cycle(1'b0, 1'b1, 8'($urandom));
    end
    repeat (8) cycle(1'b0, 1'b0, 8'h00);
    check("count_wrap", 32'(data_count), 32'd0);
    check("no_overrun", 32'(overrun), 32'd0);

    // Mid-frame valid -> overrun, byte dropped
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'($urandom));
    repeat (16) cycle(1'b0, 1'b0, 8'h00);
    check("overrun_held", 32'(overrun), 32'd1);

    // Reset at bit 3 of a data frame, then full resync
    to_ready();
    cycle(1'b0, 1'b1, 8'h5A);
    repeat (3) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    to_ready();
    check("resync_ready_t", 32'(t), 32'(8 * SYNC - 1));

    // Random traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
